// File: rtl/ir_sensor_conditioner.sv
// Conditions four active-low IR obstacle sensors: 2-flop sync, per-channel debounce, fall pulses, serialised trigger stream.
// Optional stuck-sensor detection is built when IR_STUCK_DETECT_EN is defined; otherwise stuck is tied low.
module ir_sensor_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned STUCK_CYCLES    = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] ir_raw,
  output logic [3:0] ir_clean,
  output logic [3:0] ir_fall,
  output logic       trig_valid,
  output logic [1:0] trig_id,
  output logic       trig_ovf,
  output logic [3:0] stuck
);

  localparam int DB_W = 16;

  logic [3:0]      r_s1;
  logic [3:0]      r_s2;
  logic [3:0]      r_clean;
  logic [3:0]      r_fall;
  logic [3:0]      r_pend;
  logic            r_tv;
  logic [1:0]      r_id;
  logic            r_ovf;
  logic [DB_W-1:0] r_db_cnt [4];

  logic [3:0]      w_clean_nxt;
  logic [DB_W-1:0] w_db_cnt_nxt [4];
  logic [3:0]      w_clr;
  logic [1:0]      w_id;
  logic [3:0]      w_pend_nxt;
  logic            w_ovf_hit;

  // NOTE: every variable gets a default before any branch so no latch is inferred.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      w_clean_nxt[i]  = r_clean[i];
      w_db_cnt_nxt[i] = '0;
      if (r_s2[i] != r_clean[i]) begin
        if (r_db_cnt[i] == DB_W'(DEBOUNCE_CYCLES - 1))
          w_clean_nxt[i] = ~r_clean[i];
        else
          w_db_cnt_nxt[i] = r_db_cnt[i] + DB_W'(1);
      end
    end
  end

  // Lowest pending channel wins; a fall landing on the bit being cleared keeps it pending.
  always_comb begin
    w_id = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (r_pend[i]) w_id = 2'(i);
    end
    w_clr      = r_pend & (~r_pend + 4'd1);
    w_pend_nxt = (r_pend & ~w_clr) | r_fall;
    w_ovf_hit  = |(r_fall & r_pend & ~w_clr);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1    <= 4'hF;
      r_s2    <= 4'hF;
      r_clean <= 4'hF;
      r_fall  <= 4'h0;
      r_pend  <= 4'h0;
      r_tv    <= 1'b0;
      r_id    <= 2'd0;
      r_ovf   <= 1'b0;
      // NOTE: the four debounce counters are small state, not RAM, so they are reset with everything else.
      for (int i = 0; i < 4; i++) r_db_cnt[i] <= '0;
    end else begin
      r_s1    <= ir_raw;
      r_s2    <= r_s1;
      r_clean <= w_clean_nxt;
      r_fall  <= r_clean & ~w_clean_nxt;
      r_pend  <= w_pend_nxt;
      r_tv    <= |r_pend;
      if (|r_pend) r_id <= w_id;
      if (w_ovf_hit) r_ovf <= 1'b1;
      for (int i = 0; i < 4; i++) r_db_cnt[i] <= w_db_cnt_nxt[i];
    end
  end

  assign ir_clean   = r_clean;
  assign ir_fall    = r_fall;
  assign trig_valid = r_tv;
  assign trig_id    = r_id;
  assign trig_ovf   = r_ovf;

`ifdef IR_STUCK_DETECT_EN
  localparam int ST_W = 24;

  logic [ST_W-1:0] r_st_cnt [4];
  logic [3:0]      r_stuck;

  // Count cycles spent at 0; the count and flag drop on the edge the level returns to 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stuck <= 4'h0;
      for (int i = 0; i < 4; i++) r_st_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (w_clean_nxt[i]) begin
          r_st_cnt[i] <= '0;
          r_stuck[i]  <= 1'b0;
        end else if (!r_clean[i] && (r_st_cnt[i] != ST_W'(STUCK_CYCLES))) begin
          r_st_cnt[i] <= r_st_cnt[i] + ST_W'(1);
          if (r_st_cnt[i] + ST_W'(1) == ST_W'(STUCK_CYCLES)) r_stuck[i] <= 1'b1;
        end
      end
    end
  end

  assign stuck = r_stuck;
`else
  assign stuck = 4'b0000;
`endif

endmodule

// File: tb/tb_ir_sensor_conditioner.sv
// Bench for ir_sensor_conditioner: directed scenarios plus random sensor noise, checked every cycle against a behavioural model.
// Instance u0 uses DEBOUNCE_CYCLES=4, u1 uses DEBOUNCE_CYCLES=1; both use STUCK_CYCLES=10.
module tb_ir_sensor_conditioner;

  localparam int STK = 10;

  logic       clk = 1'b0;
  logic       rst0, rst1;
  logic [3:0] raw0, raw1;
  logic [3:0] clean0, fall0, stuck0, clean1, fall1, stuck1;
  logic       tv0, ovf0, tv1, ovf1;
  logic [1:0] id0, id1;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ir_sensor_conditioner #(.DEBOUNCE_CYCLES(4), .STUCK_CYCLES(STK)) u0 (
    .clk(clk), .rst(rst0), .ir_raw(raw0), .ir_clean(clean0), .ir_fall(fall0),
    .trig_valid(tv0), .trig_id(id0), .trig_ovf(ovf0), .stuck(stuck0)
  );

  ir_sensor_conditioner #(.DEBOUNCE_CYCLES(1), .STUCK_CYCLES(STK)) u1 (
    .clk(clk), .rst(rst1), .ir_raw(raw1), .ir_clean(clean1), .ir_fall(fall1),
    .trig_valid(tv1), .trig_id(id1), .trig_ovf(ovf1), .stuck(stuck1)
  );

  // Behavioural model state, one slot per instance.
  int       dbc [2] = '{4, 1};
  bit [3:0] m_s1 [2], m_s2 [2], m_clean [2], m_fall [2], m_pend [2], m_stuck [2];
  bit       m_tv [2], m_ovf [2];
  bit [1:0] m_id [2];
  int       m_run [2][4];
  int       m_scnt [2][4];
  bit       m_rst [2];
  int       q_ev0 [$];

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_step(int m, logic r, logic [3:0] raw);
    bit [3:0] cn;
    bit [3:0] clr;
    int       low;
    m_rst[m] = r;
    if (r) begin
      m_s1[m] = 4'hF; m_s2[m] = 4'hF; m_clean[m] = 4'hF;
      m_fall[m] = '0; m_pend[m] = '0; m_stuck[m] = '0;
      m_tv[m] = 0; m_id[m] = 0; m_ovf[m] = 0;
      for (int c = 0; c < 4; c++) begin m_run[m][c] = 0; m_scnt[m][c] = 0; end
      return;
    end
    cn = m_clean[m];
    for (int c = 0; c < 4; c++) begin
      if (m_s2[m][c] != m_clean[m][c]) begin
        m_run[m][c]++;
        if (m_run[m][c] == dbc[m]) begin cn[c] = ~cn[c]; m_run[m][c] = 0; end
      end else m_run[m][c] = 0;
    end
`ifdef IR_STUCK_DETECT_EN
    for (int c = 0; c < 4; c++) begin
      if (!m_clean[m][c] && !cn[c]) begin
        if (m_scnt[m][c] < STK) m_scnt[m][c]++;
        m_stuck[m][c] = (m_scnt[m][c] == STK);
      end else begin
        m_scnt[m][c] = 0; m_stuck[m][c] = 0;
      end
    end
`endif
    low = -1;
    for (int c = 0; c < 4; c++) if (m_pend[m][c] && low < 0) low = c;
    clr = '0;
    m_tv[m] = (low >= 0);
    if (low >= 0) begin clr[low] = 1'b1; m_id[m] = 2'(low); end
    if ((m_fall[m] & m_pend[m] & ~clr) != 0) m_ovf[m] = 1;
    m_pend[m]  = (m_pend[m] & ~clr) | m_fall[m];
    m_fall[m]  = m_clean[m] & ~cn;
    m_clean[m] = cn;
    m_s2[m]    = m_s1[m];
    m_s1[m]    = raw;
  endtask

  task automatic compare(int m, logic [3:0] cl, logic [3:0] fa, logic tv, logic [1:0] id,
                         logic ov, logic [3:0] st);
    string p;
    p = $sformatf("u%0d.", m);
    check({p, "ir_clean"},   32'(cl), 32'(m_clean[m]));
    check({p, "ir_fall"},    32'(fa), 32'(m_fall[m]));
    check({p, "trig_valid"}, 32'(tv), 32'(m_tv[m]));
    if (m_tv[m] || m_rst[m]) check({p, "trig_id"}, 32'(id), 32'(m_id[m]));
    check({p, "trig_ovf"},   32'(ov), 32'(m_ovf[m]));
    check({p, "stuck"},      32'(st), 32'(m_stuck[m]));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step(0, rst0, raw0);
    model_step(1, rst1, raw1);
    @(negedge clk);
    compare(0, clean0, fall0, tv0, id0, ovf0, stuck0);
    compare(1, clean1, fall1, tv1, id1, ovf1, stuck1);
    if (tv0) q_ev0.push_back(int'(id0));
  endtask

  // Edges until u0.ir_clean[ch] reaches val; -1 if the bound expires.
  task automatic wait_clean0(int ch, logic val, output int n);
    n = -1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (clean0[ch] === val) begin n = k; break; end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit seen;
    rst0 = 1'b1; rst1 = 1'b1;
    raw0 = 4'h0; raw1 = 4'hF;

    // 1: reset then all sensors blocked
    tick(); tick();
    check("t1_reset_clean", 32'(clean0), 32'hF);
    check("t1_reset_id", 32'(id0), 32'h0);
    rst0 = 1'b0; rst1 = 1'b0;
    q_ev0.delete();
    wait_clean0(0, 1'b0, n);
    check("t1_latency", n, 6);
    check("t1_clean_all", 32'(clean0), 32'h0);
    check("t1_fall_all", 32'(fall0), 32'hF);
    repeat (6) tick();
    check("t1_events", q_ev0.size(), 4);
    for (int k = 0; k < 4; k++)
      check($sformatf("t1_id%0d", k), (q_ev0.size() > k) ? q_ev0[k] : -1, k);
    check("t1_ovf", 32'(ovf0), 32'h0);

    // 2: single-channel debounce both ways
    raw0 = 4'hF;
    repeat (12) tick();
    q_ev0.delete();
    raw0 = 4'b1110;
    wait_clean0(0, 1'b0, n);
    check("t2_fall_latency", n, 6);
    check("t2_fall_pulse", 32'(fall0), 32'h1);
    repeat (6) tick();
    check("t2_events", q_ev0.size(), 1);
    check("t2_id", (q_ev0.size() > 0) ? q_ev0[0] : -1, 0);
    q_ev0.delete();
    raw0 = 4'hF;
    wait_clean0(0, 1'b1, n);
    check("t2_rise_latency", n, 6);
    repeat (6) tick();
    check("t2_rise_events", q_ev0.size(), 0);

    // 3: three-cycle glitch rejected, four-cycle pulse accepted
    q_ev0.delete();
    seen = 0;
    for (int k = 0; k < 13; k++) begin
      raw0 = (k < 3) ? 4'b1011 : 4'hF;
      tick();
      if (clean0 !== 4'hF || fall0 !== 4'h0) seen = 1;
    end
    check("t3_glitch_outputs", 32'(seen), 32'h0);
    check("t3_glitch_events", q_ev0.size(), 0);
    raw0 = 4'b1011;
    repeat (4) tick();
    raw0 = 4'hF;
    repeat (16) tick();
    check("t3_pulse_events", q_ev0.size(), 1);
    check("t3_pulse_id", (q_ev0.size() > 0) ? q_ev0[0] : -1, 2);

    // 4: reset in the middle of a debounce
    raw0 = 4'b1101;
    repeat (3) tick();
    rst0 = 1'b1;
    tick();
    rst0 = 1'b0;
    q_ev0.delete();
    wait_clean0(1, 1'b0, n);
    check("t4_latency", n, 6);
    check("t4_no_stale_event", q_ev0.size(), 0);
    raw0 = 4'hF;
    repeat (14) tick();

    // 5: overflow on the fast instance
    for (int k = 0; k < 16; k++) begin
      raw1 = {k[0], 2'b00, k[0]};
      tick();
    end
    check("t5_ovf_set", 32'(ovf1), 32'h1);
    raw1 = 4'hF;
    repeat (10) tick();
    check("t5_ovf_sticky", 32'(ovf1), 32'h1);
    rst1 = 1'b1;
    tick();
    check("t5_ovf_reset", 32'(ovf1), 32'h0);
    rst1 = 1'b0;

    // 6: stuck sensor on channel 3
    raw0 = 4'b0111;
    wait_clean0(3, 1'b0, n);
    check("t6_fall_latency", n, 6);
`ifdef IR_STUCK_DETECT_EN
    n = -1;
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (stuck0[3] === 1'b1) begin n = k; break; end
    end
    check("t6_stuck_latency", n, STK);
`else
    repeat (20) tick();
    check("t6_stuck_off", 32'(stuck0), 32'h0);
`endif
    raw0 = 4'hF;
    wait_clean0(3, 1'b1, n);
    check("t6_rise_latency", n, 6);
    check("t6_stuck_clear", 32'(stuck0[3]), 32'h0);

    // Random sensor noise on both instances with occasional resets
    for (int k = 0; k < 400; k++) begin
      for (int c = 0; c < 4; c++) begin
        if ($urandom_range(0, 5) == 0) raw0[c] = ~raw0[c];
        if ($urandom_range(0, 1) == 0) raw1[c] = ~raw1[c];
      end
      rst0 = ($urandom_range(0, 149) == 0);
      rst1 = ($urandom_range(0, 149) == 0);
      tick();
    end
    rst0 = 1'b0; rst1 = 1'b0;
    repeat (4) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
